// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and SRAM slave FSM state type.
package ahb_lite_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned WCNT_W = 3;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DATA = 2'b01,
      ST_ERR1 = 2'b10,
      ST_ERR2 = 2'b11
   } state_e;

   // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops.
   function automatic logic is_active(input logic [1:0] htrans);
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus signals between a master/interconnect and the SRAM slave.
interface ahb_lite_sram_slave_if;

   logic                           HSEL;
   logic [31:0]                    HADDR;
   logic [1:0]                     HTRANS;
   logic                           HWRITE;
   logic [ahb_lite_pkg::DATA_W-1:0] HWDATA;
   logic                           HREADY;
   logic [ahb_lite_pkg::DATA_W-1:0] HRDATA;
   logic                           HREADYOUT;
   logic                           HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );

endinterface

// File: rtl/ahb_lite_sram_array.sv
// Word-wide SRAM: synchronous write, asynchronous read; contents are never reset.
module ahb_lite_sram_array
   import ahb_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR response
// for addresses beyond the array.
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   ahb_lite_sram_slave_if.slave bus
);

   state_e                  state_q, state_d;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic                    write_q, write_d;

   logic                    accept_c;
   logic                    in_range_c;
   logic                    launch_c;
   logic                    mem_we_c;
   logic                    hreadyout_c;
   hresp_e                  hresp_c;
   logic [DATA_W-1:0]       hrdata_c;
   logic [DATA_W-1:0]       mem_rdata_c;
   logic                    unused_addr_lsb;

   assign accept_c        = bus.HSEL & is_active(bus.HTRANS) & bus.HREADY;
   assign in_range_c      = (bus.HADDR[31:ADDR_WIDTH+2] == '0);
   assign unused_addr_lsb = &{1'b0, bus.HADDR[1:0]};

   // Next state and bus responses; a new address phase may only launch when the
   // slave is not stalling the bus (IDLE, last DATA cycle, second ERROR cycle).
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      idx_d       = idx_q;
      write_d     = write_q;
      launch_c    = 1'b0;
      mem_we_c    = 1'b0;
      hreadyout_c = 1'b1;
      hresp_c     = HRESP_OKAY;
      hrdata_c    = '0;

      case (state_q)
         ST_IDLE: launch_c = 1'b1;
         ST_DATA: begin
            hreadyout_c = (wcnt_q == '0);
            if (!write_q) hrdata_c = mem_rdata_c;
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end else begin
               mem_we_c = write_q;
               launch_c = 1'b1;
            end
         end
         ST_ERR1: begin
            hreadyout_c = 1'b0;
            hresp_c     = HRESP_ERROR;
            state_d     = ST_ERR2;
         end
         ST_ERR2: begin
            hresp_c  = HRESP_ERROR;
            launch_c = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (launch_c) begin
         state_d = ST_IDLE;
         if (accept_c) begin
            idx_d   = bus.HADDR[ADDR_WIDTH+1:2];
            write_d = bus.HWRITE;
            if (in_range_c) begin
               state_d = ST_DATA;
               wcnt_d  = WCNT_W'(WAIT_STATES);
            end else begin
               state_d = ST_ERR1;
               wcnt_d  = '0;
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
      end
   end

   ahb_lite_sram_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (HCLK),
      .we    (mem_we_c),
      .addr  (idx_q),
      .wdata (bus.HWDATA),
      .rdata (mem_rdata_c)
   );

   assign bus.HREADYOUT = hreadyout_c;
   assign bus.HRESP     = hresp_c;
   assign bus.HRDATA    = hrdata_c;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for the AHB-Lite SRAM slave at 0, 2 and 3 wait states.
module tb_ahb_lite_sram_slave;
   import ahb_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel;
   int          sel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hready_en;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ahb_lite_sram_slave_if if0 ();
   ahb_lite_sram_slave_if if2 ();
   ahb_lite_sram_slave_if if3 ();

   assign if0.HSEL   = hsel && (sel == 0);
   assign if0.HADDR  = haddr;
   assign if0.HTRANS = htrans;
   assign if0.HWRITE = hwrite;
   assign if0.HWDATA = hwdata;
   assign if0.HREADY = if0.HREADYOUT & hready_en;

   assign if2.HSEL   = hsel && (sel == 2);
   assign if2.HADDR  = haddr;
   assign if2.HTRANS = htrans;
   assign if2.HWRITE = hwrite;
   assign if2.HWDATA = hwdata;
   assign if2.HREADY = if2.HREADYOUT & hready_en;

   assign if3.HSEL   = hsel && (sel == 3);
   assign if3.HADDR  = haddr;
   assign if3.HTRANS = htrans;
   assign if3.HWRITE = hwrite;
   assign if3.HWDATA = hwdata;
   assign if3.HREADY = if3.HREADYOUT & hready_en;

   ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (.HCLK(clk), .HRESETn(rst_n), .bus(if0));
   ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut2 (.HCLK(clk), .HRESETn(rst_n), .bus(if2));
   ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (.HCLK(clk), .HRESETn(rst_n), .bus(if3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input logic [1:0] t, input logic w, input logic [31:0] a);
      sel    = s;
      hsel   = 1'b1;
      htrans = t;
      hwrite = w;
      haddr  = a;
   endtask

   task automatic bus_idle;
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
      hwrite = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; hsel = 1'b0; sel = 0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      haddr = '0; hwdata = '0; hready_en = 1'b1;

      // Reset values
      #12;
      chk1("rst_rdy0", if0.HREADYOUT, 1'b1);
      chk1("rst_resp0", if0.HRESP, 1'b0);
      chk("rst_rdata0", if0.HRDATA, 32'h0);
      chk1("rst_rdy3", if3.HREADYOUT, 1'b1);
      tick;
      rst_n = 1'b1;

      // Known value at word 0 for the out-of-range alias check
      drive(0, HTRANS_NONSEQ, 1'b1, 32'h0);
      tick;
      chk1("w0_rdy", if0.HREADYOUT, 1'b1);
      bus_idle; hwdata = 32'hA5A5A5A5;
      tick;

      // Zero wait states: write then read with an idle gap
      drive(0, HTRANS_NONSEQ, 1'b1, 32'h10);
      tick;
      chk1("w10_rdy", if0.HREADYOUT, 1'b1);
      chk("w10_rdata", if0.HRDATA, 32'h0);
      bus_idle; hwdata = 32'h11111111;
      tick;
      chk1("w10_idle_rdy", if0.HREADYOUT, 1'b1);
      drive(0, HTRANS_NONSEQ, 1'b0, 32'h10);
      tick;
      chk("r10_data", if0.HRDATA, 32'h11111111);
      chk1("r10_rdy", if0.HREADYOUT, 1'b1);
      bus_idle;
      tick;
      chk("idle_rdata", if0.HRDATA, 32'h0);

      // Back-to-back write then read of the same word
      drive(0, HTRANS_NONSEQ, 1'b1, 32'h20);
      tick;
      hwdata = 32'h22222222;
      drive(0, HTRANS_SEQ, 1'b0, 32'h20);
      tick;
      chk("b2b_data", if0.HRDATA, 32'h22222222);
      chk1("b2b_rdy", if0.HREADYOUT, 1'b1);
      bus_idle;
      tick;

      // Out-of-range write: two-cycle ERROR, word 0 untouched
      drive(0, HTRANS_NONSEQ, 1'b1, 32'h00010000);
      tick;
      chk1("err1_rdy", if0.HREADYOUT, 1'b0);
      chk1("err1_resp", if0.HRESP, 1'b1);
      bus_idle; hwdata = 32'hDEADBEEF;
      tick;
      chk1("err2_rdy", if0.HREADYOUT, 1'b1);
      chk1("err2_resp", if0.HRESP, 1'b1);
      tick;
      chk1("err_done_resp", if0.HRESP, 1'b0);
      drive(0, HTRANS_NONSEQ, 1'b0, 32'h0);
      tick;
      chk("r0_data", if0.HRDATA, 32'hA5A5A5A5);
      bus_idle;
      tick;

      // Non-transfers: HSEL low, IDLE, BUSY, HREADY low
      hwdata = 32'hFFFFFFFF;
      drive(0, HTRANS_NONSEQ, 1'b1, 32'h10);
      hsel = 1'b0;
      tick;
      chk1("nosel_rdy", if0.HREADYOUT, 1'b1);
      drive(0, HTRANS_IDLE, 1'b1, 32'h10);
      tick;
      chk1("htidle_rdy", if0.HREADYOUT, 1'b1);
      drive(0, HTRANS_BUSY, 1'b1, 32'h10);
      tick;
      chk1("busy_rdy", if0.HREADYOUT, 1'b1);
      drive(0, HTRANS_NONSEQ, 1'b1, 32'h10);
      hready_en = 1'b0;
      tick;
      chk1("nohready_rdy", if0.HREADYOUT, 1'b1);
      chk1("nohready_resp", if0.HRESP, 1'b0);
      hready_en = 1'b1;
      bus_idle;
      tick;
      drive(0, HTRANS_NONSEQ, 1'b0, 32'h10);
      tick;
      chk("r10_keep", if0.HRDATA, 32'h11111111);
      bus_idle;
      tick;

      // Two wait states
      drive(2, HTRANS_NONSEQ, 1'b1, 32'h10);
      tick;
      chk1("ws2_w_rdy_a", if2.HREADYOUT, 1'b0);
      bus_idle; hwdata = 32'h11111111;
      tick;
      chk1("ws2_w_rdy_b", if2.HREADYOUT, 1'b0);
      tick;
      chk1("ws2_w_rdy_c", if2.HREADYOUT, 1'b1);
      tick;
      drive(2, HTRANS_NONSEQ, 1'b0, 32'h10);
      tick;
      chk1("ws2_r_rdy1", if2.HREADYOUT, 1'b0);
      chk("ws2_r_data1", if2.HRDATA, 32'h11111111);
      bus_idle;
      tick;
      chk1("ws2_r_rdy2", if2.HREADYOUT, 1'b0);
      tick;
      chk1("ws2_r_rdy3", if2.HREADYOUT, 1'b1);
      chk("ws2_r_data3", if2.HRDATA, 32'h11111111);
      tick;
      chk1("ws2_idle_rdy", if2.HREADYOUT, 1'b1);
      chk("ws2_idle_data", if2.HRDATA, 32'h0);

      // Three wait states: establish a prior value at 0x30
      drive(3, HTRANS_NONSEQ, 1'b1, 32'h30);
      tick;
      bus_idle; hwdata = 32'h12345678;
      tick;
      tick;
      tick;
      chk1("ws3_w_rdy", if3.HREADYOUT, 1'b1);
      tick;

      // Write interrupted by reset in its second wait cycle
      drive(3, HTRANS_NONSEQ, 1'b1, 32'h30);
      tick;
      chk1("ws3_wait1", if3.HREADYOUT, 1'b0);
      bus_idle; hwdata = 32'h33333333;
      tick;
      chk1("ws3_wait2", if3.HREADYOUT, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("ws3_rst_rdy", if3.HREADYOUT, 1'b1);
      chk1("ws3_rst_resp", if3.HRESP, 1'b0);
      chk("ws3_rst_rdata", if3.HRDATA, 32'h0);
      tick;
      rst_n = 1'b1;
      tick;
      drive(3, HTRANS_NONSEQ, 1'b0, 32'h30);
      tick;
      chk1("ws3_r_rdy1", if3.HREADYOUT, 1'b0);
      chk("ws3_r_data1", if3.HRDATA, 32'h12345678);
      bus_idle;
      tick;
      tick;
      tick;
      chk1("ws3_r_rdy4", if3.HREADYOUT, 1'b1);
      chk("ws3_r_data4", if3.HRDATA, 32'h12345678);
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ahb_lite_sram_slave.md
AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, memory depth 2^ADDR_WIDTH 32-bit words, word index HADDR[ADDR_WIDTH+1:2].
REQ-002 Parameter WAIT_STATES, default 0, range 0..7, HREADYOUT-low cycles inserted per in-range data phase.
REQ-003 Clocking is fixed: single clock HCLK; reset HRESETn is asynchronous and active-low.
REQ-004 Port: HCLK  input  1  system clock, all state on rising edge.
REQ-005 Port: HRESETn  input  1  asynchronous active-low reset.
REQ-006 Port: HSEL  input  1  slave select.
REQ-007 Port: HADDR  input  32  byte address from master.
REQ-008 Port: HTRANS  input  2  transfer type; masters without HTRANS tie it to 2'b10 (NONSEQ).
REQ-009 Port: HWRITE  input  1  1 = write, 0 = read.
REQ-010 Port: HWDATA  input  32  write data, valid in data phase.
REQ-011 Port: HREADY  input  1  bus ready, the combined HREADY fed back to the master.
REQ-012 Port: HRDATA  output  32  read data.
REQ-013 Port: HREADYOUT  output  1  slave ready.
REQ-014 Port: HRESP  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-015 Address phase SHALL be accepted when HSEL & HTRANS[1] & HREADY at a rising edge; the edge captures word index, HWRITE and in-range flag (HADDR[31:ADDR_WIDTH+2]==0).
REQ-016 HADDR[1:0] SHALL be ignored; all accesses are full 32-bit words.
REQ-017 FSM states: IDLE, DATA, ERR1, ERR2; wait counter wcnt is 3 bits.
REQ-018 IDLE: HREADYOUT=1, HRESP=0; an accepted in-range phase goes to DATA with wcnt=WAIT_STATES; an accepted out-of-range phase goes to ERR1.
REQ-019 DATA: HREADYOUT=(wcnt==0), HRESP=0; while wcnt>0, decrement each cycle.
REQ-020 DATA with wcnt==0 completes the transfer; an address phase accepted on that same edge re-enters DATA or ERR1 (back-to-back pipelining, no bubble), else IDLE.
REQ-021 Write SHALL commit mem[index]=HWDATA only on the edge where state==DATA, wcnt==0 and captured write==1.
REQ-022 Read: HRDATA=mem[index] combinationally throughout a read DATA phase; HRDATA=32'h0 in every other state and during writes.
REQ-023 Read immediately after write to the same index SHALL return the new data (write commits before read data phase begins).
REQ-024 ERR1: HREADYOUT=0, HRESP=1, next state ERR2 unconditionally; ERR2: HREADYOUT=1, HRESP=1, then next state per REQ-020; no memory write; wait states not applied.
REQ-025 IDLE/BUSY transfers, or HSEL=0, SHALL produce no state change and no memory access.
REQ-026 Address phases presented while HREADY=0 SHALL be ignored.

Reset
REQ-027 HRESETn low SHALL immediately force state=IDLE, wcnt=0, HREADYOUT=1, HRESP=0, HRDATA=32'h0, regardless of phase in progress.
REQ-028 A write whose data phase is interrupted by reset SHALL NOT commit; memory contents are not reset.

Structure
REQ-029 Package ahb_lite_pkg holds HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HRESP values and the FSM state encoding.
REQ-030 Storage SHALL be a sub-module ahb_lite_sram_array (synchronous write port, asynchronous read port, depth 2^ADDR_WIDTH x 32).

Verification
REQ-031 WAIT_STATES=0: write 32'h11111111 to 32'h00000010, then read 32'h00000010 -> HRDATA=32'h11111111 in read data phase, HREADYOUT never low.
REQ-032 WAIT_STATES=0: back-to-back write 32'h22222222 @32'h20 then read @32'h20 on consecutive cycles -> read returns 32'h22222222, no inserted cycle.
REQ-033 WAIT_STATES=2: read @32'h10 -> HREADYOUT low exactly 2 cycles, third data cycle HREADYOUT=1 with HRDATA=32'h11111111.
REQ-034 Write 32'hDEADBEEF @32'h00010000 (out of range, ADDR_WIDTH=10) -> one cycle HREADYOUT=0/HRESP=1, one cycle 1/1; readback @32'h00000000 unchanged.
REQ-035 HSEL=0 or HTRANS=2'b00 with HWRITE=1, HWDATA=32'hFFFFFFFF @32'h10 -> HREADYOUT stays 1, readback still 32'h11111111.
REQ-036 WAIT_STATES=3: write 32'h33333333 @32'h30, assert HRESETn=0 in second wait cycle -> HREADYOUT=1, HRESP=0 immediately; readback @32'h30 holds prior value.
